// File: rtl/get_local_unit.sv
// get_local execution unit: bounds-checks a local index, reads the slot from stack memory
// and pushes value+type onto the operand stack. Optional type check under `LOCAL_TYPECHECK_EN`.
//
// state   | meaning
// IDLE    | waiting for start
// READ    | memory latency cycle, address already presented
// CAPTURE | register read data/type (type check when enabled)
// PUSH    | push_valid held until push_ready
// DONE    | one-cycle done pulse
// TRAP    | sticky error, left only by reset
module get_local_unit #(
   parameter int STACK_DEPTH = 7
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [31:0]            local_index,
   input  logic [31:0]            num_locals,
   input  logic [STACK_DEPTH:0]   frame_base,
   input  logic [STACK_DEPTH:0]   sp,
   output logic [STACK_DEPTH:0]   mem_raddr,
   input  logic [63:0]            mem_rdata,
   input  logic [1:0]             mem_rtype,
`ifdef LOCAL_TYPECHECK_EN
   input  logic [1:0]             expected_type,
`endif
   output logic                   push_valid,
   input  logic                   push_ready,
   output logic [63:0]            push_data,
   output logic [1:0]             push_type,
   output logic                   busy,
   output logic                   done,
   output logic [3:0]             trap
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_CAPTURE = 3'd2,
      S_PUSH    = 3'd3,
      S_DONE    = 3'd4,
      S_TRAP    = 3'd5
   } state_t;

   localparam logic [3:0] TRAP_NONE     = 4'd0;
   localparam logic [3:0] TRAP_OVERFLOW = 4'd1;
   localparam logic [3:0] TRAP_RANGE    = 4'd2;
   localparam logic [3:0] TRAP_TYPE     = 4'd3;

   // sp >= 2**STACK_DEPTH is exactly "top bit set" for a STACK_DEPTH+1 bit pointer
   localparam logic [STACK_DEPTH:0] SP_FULL = {1'b1, {STACK_DEPTH{1'b0}}};

   state_t                 state_q;
   logic [STACK_DEPTH:0]   raddr_q, raddr_d;
   logic                   push_valid_q;
   logic [63:0]            push_data_q;
   logic [1:0]             push_type_q;
   logic                   busy_q;
   logic                   done_q;
   logic [3:0]             trap_q;
   logic                   idx_oob_d;
   logic                   stack_full_d;
`ifdef LOCAL_TYPECHECK_EN
   logic [1:0]             exp_type_q;
`endif

   always_comb begin
      idx_oob_d    = (local_index >= num_locals);
      stack_full_d = (sp >= SP_FULL);
      raddr_d      = frame_base + local_index[STACK_DEPTH:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         raddr_q      <= '0;
         push_valid_q <= 1'b0;
         push_data_q  <= '0;
         push_type_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         trap_q       <= TRAP_NONE;
`ifdef LOCAL_TYPECHECK_EN
         exp_type_q   <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  if (idx_oob_d) begin
                     trap_q  <= TRAP_RANGE;
                     state_q <= S_TRAP;
                  end else if (stack_full_d) begin
                     trap_q  <= TRAP_OVERFLOW;
                     state_q <= S_TRAP;
                  end else begin
                     raddr_q <= raddr_d;
                     busy_q  <= 1'b1;
                     state_q <= S_READ;
`ifdef LOCAL_TYPECHECK_EN
                     exp_type_q <= expected_type;
`endif
                  end
               end
            end
            S_READ: state_q <= S_CAPTURE;
            S_CAPTURE: begin
`ifdef LOCAL_TYPECHECK_EN
               if (mem_rtype != exp_type_q) begin
                  trap_q  <= TRAP_TYPE;
                  busy_q  <= 1'b0;
                  state_q <= S_TRAP;
               end else begin
                  push_data_q  <= mem_rdata;
                  push_type_q  <= mem_rtype;
                  push_valid_q <= 1'b1;
                  state_q      <= S_PUSH;
               end
`else
               push_data_q  <= mem_rdata;
               push_type_q  <= mem_rtype;
               push_valid_q <= 1'b1;
               state_q      <= S_PUSH;
`endif
            end
            S_PUSH: begin
               if (push_ready) begin
                  push_valid_q <= 1'b0;
                  done_q       <= 1'b1;
                  state_q      <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            S_TRAP:  state_q <= S_TRAP;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_raddr  = raddr_q;
   assign push_valid = push_valid_q;
   assign push_data  = push_data_q;
   assign push_type  = push_type_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign trap       = trap_q;

endmodule
